nco_cfg_scheduler: RTL
======================

# nco_cfg_scheduler

Configuration scheduler between the I2C register slave and the NCO core. Captures host-written configuration into a shadow set and commits it to the NCO only on a phase-wrap boundary, so the output never glitches mid-period. Optionally runs a linear frequency sweep from the committed start frequency toward a stop frequency, one step per dwell interval. A new host write always overrides a running sweep.

## Interface
- FREQ_W, 64, frequency tuning word width
- DUTY_W, 16, duty-cycle word width
- HOLD_W, 32, dwell counter width (clk cycles)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- host_valid  in  1  one-cycle strobe: host_* fields valid, capture into shadow
- host_enable  in  1  requested NCO enable
- host_wave  in  2  requested waveform code
- host_freq  in  FREQ_W  requested frequency / sweep start
- host_duty  in  DUTY_W  requested duty cycle
- host_sweep_en  in  1  run sweep after commit
- sweep_step  in  FREQ_W  per-step frequency increment (sampled on host_valid)
- sweep_stop  in  FREQ_W  sweep end frequency (sampled on host_valid)
- sweep_hold  in  HOLD_W  dwell cycles per step (sampled on host_valid)
- nco_wrap  in  1  one-cycle pulse from NCO at phase-accumulator wrap
- nco_enable  out  1  applied enable
- nco_wave  out  2  applied waveform
- nco_freq  out  FREQ_W  applied frequency
- nco_duty  out  DUTY_W  applied duty cycle
- cfg_pending  out  1  shadow holds an uncommitted configuration
- sweep_active  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse when sweep reaches stop

## Operation
- States: IDLE, PENDING, DWELL, STEP_WAIT.
- IDLE: host_valid -> capture all host_* and sweep_* into shadow, go PENDING.
- PENDING: commit shadow to nco_* when nco_wrap=1, or on the first PENDING cycle if nco_enable=0 (NCO stopped, no boundary needed). After commit: if shadow sweep_en=1, host_enable=1, step!=0 and host_freq<stop -> DWELL with dwell counter loaded to sweep_hold; if sweep_en=1 but any of those fail -> pulse sweep_done, IDLE; else IDLE.
- DWELL: counter decrements each cycle; at 0 -> STEP_WAIT. sweep_hold=0 means step on the next wrap.
- STEP_WAIT: on nco_wrap, nco_freq <= min(nco_freq+step, stop), computed at FREQ_W+1 bits; carry-out saturates to stop. If result == stop -> pulse sweep_done, IDLE; else DWELL, reload counter.
- host_valid in any state: shadow overwritten (last write wins), sweep aborted, go PENDING. nco_* keep current values until the new commit.
- host_valid and nco_wrap in the same cycle: capture wins; that wrap does not commit; commit on a later wrap.
- sweep_active = state in {DWELL, STEP_WAIT}; cfg_pending = state == PENDING.
- nco_enable, nco_wave, nco_duty change only at commit; sweep changes nco_freq only.

## Timing
- All outputs registered. Reset: nco_enable=0, nco_wave=0, nco_freq=0, nco_duty=0, cfg_pending=0, sweep_active=0, sweep_done=0, state IDLE, shadow cleared.
- host_valid at cycle N -> cfg_pending=1 at N+1.
- nco_wrap at cycle M (in PENDING) -> nco_* updated, cfg_pending=0 at M+1.
- Stopped NCO: host_valid at N -> commit visible at N+2.
- Sweep step: wrap at M in STEP_WAIT -> new nco_freq at M+1; sweep_done high exactly one cycle, coincident with final nco_freq.
- rst mid-sweep or mid-pending: immediate return to reset values; no partial commit.

## Structure
- Shared package nco_pkg: FREQ_W, DUTY_W, waveform code constants, scheduler state enum; shared with the I2C slave and NCO core.
- One sub-module: nco_sweep_step (combinational saturating add: freq, step, stop -> next_freq, at_stop).

## Test plan
- NCO running, host_valid freq=0x1000, duty=0x8000, wave=2 -> cfg_pending=1, nco_* unchanged until next nco_wrap, then applied one cycle later.
- nco_enable=0, host_valid enable=1 freq=0x40 -> nco_enable=1, nco_freq=0x40 two cycles after strobe, no wrap needed.
- Sweep start=100, step=30, stop=190, hold=4 -> nco_freq 100,130,160,190 each after ≥4 dwell cycles plus a wrap; sweep_done one pulse with 190.
- Sweep start=2^64-10, step=20, stop=2^64-1 -> carry saturates, nco_freq=2^64-1, sweep_done pulses.
- host_valid freq=0x55 during DWELL, asserted on the same cycle as nco_wrap -> sweep_active=0, no commit that cycle, 0x55 applied on the following wrap.
- rst asserted while PENDING -> all outputs zero next edge, subsequent wrap commits nothing.

Source files
------------

// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared NCO widths, waveform codes and scheduler state encoding
package nco_pkg;

  localparam int FREQ_W = 64;
  localparam int DUTY_W = 16;
  localparam int HOLD_W = 32;
  localparam int WAVE_W = 2;

  localparam logic [WAVE_W-1:0] WAVE_SINE     = 2'd0;
  localparam logic [WAVE_W-1:0] WAVE_SQUARE   = 2'd1;
  localparam logic [WAVE_W-1:0] WAVE_TRIANGLE = 2'd2;
  localparam logic [WAVE_W-1:0] WAVE_SAW      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PENDING   = 2'd1,
    ST_DWELL     = 2'd2,
    ST_STEP_WAIT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/nco_cfg_scheduler_if.sv
// rtl/nco_cfg_scheduler_if.sv - host/NCO side signal bundle of the configuration scheduler
interface nco_cfg_scheduler_if #(
  parameter int FREQ_W = nco_pkg::FREQ_W,
  parameter int DUTY_W = nco_pkg::DUTY_W,
  parameter int HOLD_W = nco_pkg::HOLD_W
);

  logic              host_valid;
  logic              host_enable;
  logic [1:0]        host_wave;
  logic [FREQ_W-1:0] host_freq;
  logic [DUTY_W-1:0] host_duty;
  logic              host_sweep_en;
  logic [FREQ_W-1:0] sweep_step;
  logic [FREQ_W-1:0] sweep_stop;
  logic [HOLD_W-1:0] sweep_hold;
  logic              nco_wrap;

  logic              nco_enable;
  logic [1:0]        nco_wave;
  logic [FREQ_W-1:0] nco_freq;
  logic [DUTY_W-1:0] nco_duty;
  logic              cfg_pending;
  logic              sweep_active;
  logic              sweep_done;

  // master = register slave + NCO core side; slave = scheduler
  modport master (
    output host_valid, host_enable, host_wave, host_freq, host_duty, host_sweep_en,
    output sweep_step, sweep_stop, sweep_hold, nco_wrap,
    input  nco_enable, nco_wave, nco_freq, nco_duty, cfg_pending, sweep_active, sweep_done
  );

  modport slave (
    input  host_valid, host_enable, host_wave, host_freq, host_duty, host_sweep_en,
    input  sweep_step, sweep_stop, sweep_hold, nco_wrap,
    output nco_enable, nco_wave, nco_freq, nco_duty, cfg_pending, sweep_active, sweep_done
  );

endinterface

// File: rtl/nco_sweep_step.sv
// rtl/nco_sweep_step.sv - saturating sweep increment: min(freq + step, stop) with carry-out guard
module nco_sweep_step
  import nco_pkg::*;
(
  input  logic [FREQ_W-1:0] freq,
  input  logic [FREQ_W-1:0] step,
  input  logic [FREQ_W-1:0] stop,
  output logic [FREQ_W-1:0] next_freq,
  output logic              at_stop
);

  logic [FREQ_W:0] sum;

  assign sum = {1'b0, freq} + {1'b0, step};

  // A carry out means the true sum is beyond any representable stop value.
  always_comb begin
    next_freq = sum[FREQ_W-1:0];
    at_stop   = 1'b0;
    if (sum[FREQ_W] || (sum[FREQ_W-1:0] >= stop)) begin
      next_freq = stop;
      at_stop   = 1'b1;
    end
  end

endmodule

// File: rtl/nco_cfg_scheduler.sv
// rtl/nco_cfg_scheduler.sv - shadows host configuration, commits on NCO phase wrap, runs linear sweeps
module nco_cfg_scheduler
  import nco_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  nco_cfg_scheduler_if.slave bus
);

  sched_state_t state, state_nxt;

  logic              sh_enable;
  logic [1:0]        sh_wave;
  logic [FREQ_W-1:0] sh_freq;
  logic [DUTY_W-1:0] sh_duty;
  logic              sh_sweep_en;
  logic [FREQ_W-1:0] sh_step;
  logic [FREQ_W-1:0] sh_stop;
  logic [HOLD_W-1:0] sh_hold;

  logic              nco_enable_q;
  logic [1:0]        nco_wave_q;
  logic [FREQ_W-1:0] nco_freq_q;
  logic [DUTY_W-1:0] nco_duty_q;
  logic              cfg_pending_q;
  logic              sweep_active_q;
  logic              sweep_done_q;
  logic [HOLD_W-1:0] dwell_cnt;

  logic              capture;
  logic              commit;
  logic              step_apply;
  logic              load_cnt;
  logic              done_nxt;
  logic              sweep_ok;
  logic [FREQ_W-1:0] step_freq;
  logic              step_at_stop;

  assign sweep_ok = sh_sweep_en && sh_enable && (sh_step != '0) && (sh_freq < sh_stop);

  nco_sweep_step u_sweep_step (
    .freq      (nco_freq_q),
    .step      (sh_step),
    .stop      (sh_stop),
    .next_freq (step_freq),
    .at_stop   (step_at_stop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A host strobe outranks everything, including a coincident wrap.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    commit     = 1'b0;
    step_apply = 1'b0;
    load_cnt   = 1'b0;
    done_nxt   = 1'b0;
    if (bus.host_valid) begin
      capture   = 1'b1;
      state_nxt = ST_PENDING;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_PENDING: begin
          // A stopped NCO never wraps, so it takes the new setting at once.
          if (bus.nco_wrap || !nco_enable_q) begin
            commit = 1'b1;
            if (sweep_ok) begin
              state_nxt = ST_DWELL;
              load_cnt  = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
              done_nxt  = sh_sweep_en;
            end
          end
        end
        ST_DWELL: begin
          if (dwell_cnt == '0) state_nxt = ST_STEP_WAIT;
        end
        ST_STEP_WAIT: begin
          if (bus.nco_wrap) begin
            step_apply = 1'b1;
            if (step_at_stop) begin
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DWELL;
              load_cnt  = 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_enable      <= 1'b0;
      sh_wave        <= '0;
      sh_freq        <= '0;
      sh_duty        <= '0;
      sh_sweep_en    <= 1'b0;
      sh_step        <= '0;
      sh_stop        <= '0;
      sh_hold        <= '0;
      nco_enable_q   <= 1'b0;
      nco_wave_q     <= '0;
      nco_freq_q     <= '0;
      nco_duty_q     <= '0;
      cfg_pending_q  <= 1'b0;
      sweep_active_q <= 1'b0;
      sweep_done_q   <= 1'b0;
      dwell_cnt      <= '0;
    end else begin
      if (capture) begin
        sh_enable   <= bus.host_enable;
        sh_wave     <= bus.host_wave;
        sh_freq     <= bus.host_freq;
        sh_duty     <= bus.host_duty;
        sh_sweep_en <= bus.host_sweep_en;
        sh_step     <= bus.sweep_step;
        sh_stop     <= bus.sweep_stop;
        sh_hold     <= bus.sweep_hold;
      end
      if (commit) begin
        nco_enable_q <= sh_enable;
        nco_wave_q   <= sh_wave;
        nco_freq_q   <= sh_freq;
        nco_duty_q   <= sh_duty;
      end else if (step_apply) begin
        nco_freq_q <= step_freq;
      end
      if (load_cnt) dwell_cnt <= sh_hold;
      else if (state == ST_DWELL && dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
      cfg_pending_q  <= (state_nxt == ST_PENDING);
      sweep_active_q <= (state_nxt == ST_DWELL) || (state_nxt == ST_STEP_WAIT);
      sweep_done_q   <= done_nxt;
    end
  end

  assign bus.nco_enable   = nco_enable_q;
  assign bus.nco_wave     = nco_wave_q;
  assign bus.nco_freq     = nco_freq_q;
  assign bus.nco_duty     = nco_duty_q;
  assign bus.cfg_pending  = cfg_pending_q;
  assign bus.sweep_active = sweep_active_q;
  assign bus.sweep_done   = sweep_done_q;

endmodule
